multi_debouncer: RTL and testbench

Parametrised N-channel switch/button debouncer, successor to the single-channel delayed debouncer.
- One shared tick prescaler.
- Per-channel 2-FF synchroniser and 4-state FSM with a configurable stable-tick count.
- Per-channel registered level output plus single-cycle rise/fall pulses.
- Sits between raw board inputs (switches, keys) and the control FSMs.

---
 rtl/debounce_pkg.sv | 12 +
 rtl/debounce_channel.sv | 84 ++++++++
 rtl/multi_debouncer.sv | 47 ++++
 tb/tb_multi_debouncer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and counter-width helper for the debouncer channels
package debounce_pkg;
  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one synchronised, tick-qualified debounce FSM with level and edge outputs
// Optional hold counter and long-press pulse under DEBOUNCE_LONG_PRESS_EN.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 3
`ifdef DEBOUNCE_LONG_PRESS_EN
  , parameter int LONG_TICKS = 100
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_sw,
  output logic o_db,
  output logic o_rise,
  output logic o_fall,
  output logic o_long_press
);
  localparam int CW = cnt_width(STABLE_TICKS);
  logic [1:0] r_sync;
  db_state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic r_db_q;
  logic w_s, w_db, w_last;
  assign w_s = r_sync[1];
  assign w_last = i_tick && (r_cnt == CW'(STABLE_TICKS - 1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= '0;
      r_state <= ZERO;
      r_cnt   <= '0;
      r_db_q  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_sw};
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_db_q  <= w_db;
    end
  end
  // A glitch back to the old level during WAIT aborts; counting starts the cycle after entry.
  always_comb begin
    w_next = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      ZERO: if (w_s) begin
        w_next = WAIT1;
        w_cnt_next = '0;
      end
      WAIT1: if (!w_s) w_next = ZERO;
        else if (w_last) w_next = ONE;
        else if (i_tick) w_cnt_next = r_cnt + 1'b1;
      ONE: if (!w_s) begin
        w_next = WAIT0;
        w_cnt_next = '0;
      end
      WAIT0: if (w_s) w_next = ONE;
        else if (w_last) w_next = ZERO;
        else if (i_tick) w_cnt_next = r_cnt + 1'b1;
      default: w_next = ZERO;
    endcase
  end
  always_comb begin
    w_db = (r_state == ONE) || (r_state == WAIT0);
    o_rise = w_db & ~r_db_q;
    o_fall = ~w_db & r_db_q;
  end
  assign o_db = w_db;
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int HW = cnt_width(LONG_TICKS);
  logic [HW-1:0] r_hold;
  logic w_hold_inc;
  assign w_hold_inc = i_tick && w_db && (r_hold != HW'(LONG_TICKS));
  // Cleared only on a fresh press, so a release glitch back into ONE cannot re-arm the pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_hold <= '0;
    else if ((r_state == WAIT1 && w_next == ONE) || r_state == ZERO) r_hold <= '0;
    else if (w_hold_inc) r_hold <= r_hold + 1'b1;
  end
  assign o_long_press = w_hold_inc && (r_hold == HW'(LONG_TICKS - 1));
`else
  assign o_long_press = 1'b0;
`endif
endmodule

// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel debouncer sharing one sample-tick prescaler
// Long-press pulses are built only when DEBOUNCE_LONG_PRESS_EN is defined.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int N = 4,
  parameter int TICK_DIV = 500_000,
  parameter int STABLE_TICKS = 3,
  parameter int LONG_TICKS = 100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sw,
  output logic [N-1:0] db,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] long_press
);
  localparam int DW = cnt_width(TICK_DIV - 1);
  logic [DW-1:0] r_div;
  logic w_tick;
  if (N < 1 || TICK_DIV < 2 || STABLE_TICKS < 1 || LONG_TICKS < 1) begin : g_bad_param
    $error("multi_debouncer: parameter out of range");
  end
  assign w_tick = (r_div == DW'(TICK_DIV - 1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_div <= '0;
    else r_div <= w_tick ? '0 : r_div + 1'b1;
  end
  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
`ifdef DEBOUNCE_LONG_PRESS_EN
      , .LONG_TICKS(LONG_TICKS)
`endif
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .i_tick(w_tick),
      .i_sw(sw[i]),
      .o_db(db[i]),
      .o_rise(rise[i]),
      .o_fall(fall[i]),
      .o_long_press(long_press[i])
    );
  end
endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: directed self-checking bench for multi_debouncer (N=2, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=5)
module tb_multi_debouncer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] sw = 2'b00;
  logic [1:0] db, rise, fall, long_press;
  int checks = 0;
  int failures = 0;
  int rise_n[2];
  int fall_n[2];
  int long_n[2];
  always #5 clk = ~clk;
  multi_debouncer #(.N(2), .TICK_DIV(4), .STABLE_TICKS(3), .LONG_TICKS(5)) dut (
    .clk(clk), .reset(reset), .sw(sw), .db(db), .rise(rise), .fall(fall), .long_press(long_press)
  );
  task automatic step();
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      rise_n[c] += int'(rise[c]);
      fall_n[c] += int'(fall[c]);
      long_n[c] += int'(long_press[c]);
    end
  endtask
  task automatic clr();
    for (int c = 0; c < 2; c++) begin
      rise_n[c] = 0;
      fall_n[c] = 0;
      long_n[c] = 0;
    end
  endtask
  task automatic wait_db(input int ch, input logic v, input int max, output int k);
    k = 0;
    while (db[ch] !== v && k < max) begin
      step();
      k++;
    end
  endtask
  task automatic settle(input logic [1:0] v);
    sw = v;
    for (int i = 0; i < 40 && db !== v; i++) step();
  endtask
  task automatic test_reset();
    int k;
    reset = 1'b1;
    sw = 2'b00;
    step();
    step();
    checks++;
    if (db !== 2'b00 || rise !== 2'b00 || fall !== 2'b00 || long_press !== 2'b00) begin
      failures++;
      $display("FAIL reset_state: db=%b rise=%b fall=%b long=%b, want all 0", db, rise, fall, long_press);
    end
    reset = 1'b0;
    sw = 2'b11;
    clr();
    wait_db(0, 1'b1, 30, k);
    checks++;
    if (k - 1 < 11 || k - 1 > 14) begin
      failures++;
      $display("FAIL reset_first_rise: latency=%0d, want 11..14", k - 1);
    end
    step();
    step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (db !== 2'b00 || rise !== 2'b00 || fall !== 2'b00 || long_press !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_one: db=%b rise=%b fall=%b long=%b, want all 0", db, rise, fall, long_press);
    end
    step();
    reset = 1'b0;
    clr();
    for (int i = 0; i < 8; i++) step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (db !== 2'b00 || rise !== 2'b00 || fall !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_wait: db=%b rise=%b fall=%b, want all 0", db, rise, fall);
    end
    step();
    reset = 1'b0;
    wait_db(0, 1'b1, 30, k);
    checks++;
    if (k - 1 < 11 || k - 1 > 14) begin
      failures++;
      $display("FAIL reset_restart_rise: latency=%0d, want 11..14", k - 1);
    end
    checks++;
    if (fall_n[0] != 0 || rise_n[0] != 1) begin
      failures++;
      $display("FAIL reset_no_pulse: rise_n=%0d fall_n=%0d, want 1 and 0", rise_n[0], fall_n[0]);
    end
    settle(2'b00);
  endtask
  task automatic test_bounce();
    int bad = 0;
    clr();
    for (int i = 0; i < 200; i++) begin
      if (i % 3 == 0) sw[0] = ~sw[0];
      step();
      if (db[0] !== 1'b0) bad++;
    end
    sw[0] = 1'b0;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bounce_db: db0 high in %0d cycles, want 0", bad);
    end
    checks++;
    if (rise_n[0] != 0 || fall_n[0] != 0) begin
      failures++;
      $display("FAIL bounce_pulses: rise=%0d fall=%0d, want 0 and 0", rise_n[0], fall_n[0]);
    end
  endtask
  task automatic test_hold();
    int k;
    clr();
    sw[0] = 1'b1;
    wait_db(0, 1'b1, 30, k);
    checks++;
    if (k - 1 < 11 || k - 1 > 14) begin
      failures++;
      $display("FAIL hold_latency: latency=%0d, want 11..14", k - 1);
    end
    checks++;
    if (rise[0] !== 1'b1) begin
      failures++;
      $display("FAIL hold_rise_align: rise0=%b at first db cycle, want 1", rise[0]);
    end
    step();
    checks++;
    if (rise[0] !== 1'b0) begin
      failures++;
      $display("FAIL hold_rise_width: rise0=%b one cycle later, want 0", rise[0]);
    end
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (rise_n[0] != 1 || fall_n[0] != 0 || db[0] !== 1'b1) begin
      failures++;
      $display("FAIL hold_pulses: rise=%0d fall=%0d db0=%b, want 1 0 1", rise_n[0], fall_n[0], db[0]);
    end
  endtask
  task automatic test_glitch();
    int k;
    int bad = 0;
    clr();
    sw[0] = 1'b0;
    step();
    sw[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (db[0] !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || fall_n[0] != 0) begin
      failures++;
      $display("FAIL glitch_hold: low cycles=%0d fall=%0d, want 0 and 0", bad, fall_n[0]);
    end
    sw[0] = 1'b0;
    wait_db(0, 1'b0, 30, k);
    checks++;
    if (k - 1 < 11 || k - 1 > 14) begin
      failures++;
      $display("FAIL release_latency: latency=%0d, want 11..14", k - 1);
    end
    checks++;
    if (fall[0] !== 1'b1) begin
      failures++;
      $display("FAIL release_fall_align: fall0=%b, want 1", fall[0]);
    end
    step();
    checks++;
    if (fall_n[0] != 1 || fall[0] !== 1'b0) begin
      failures++;
      $display("FAIL release_fall_once: fall_n=%0d fall0=%b, want 1 and 0", fall_n[0], fall[0]);
    end
  endtask
  task automatic test_simultaneous();
    int k;
    clr();
    sw = 2'b01;
    wait_db(0, 1'b1, 30, k);
    checks++;
    if (db !== 2'b01 || rise !== 2'b01) begin
      failures++;
      $display("FAIL simul_first: db=%b rise=%b, want 01 01", db, rise);
    end
    sw = 2'b10;
    k = 0;
    while (db !== 2'b10 && k < 30) begin
      step();
      k++;
    end
    checks++;
    if (k - 1 < 11 || k - 1 > 14) begin
      failures++;
      $display("FAIL simul_latency: latency=%0d, want 11..14", k - 1);
    end
    checks++;
    if (rise !== 2'b10 || fall !== 2'b01) begin
      failures++;
      $display("FAIL simul_align: rise=%b fall=%b, want 10 01", rise, fall);
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (rise_n[1] != 1 || fall_n[0] != 1 || rise_n[0] != 1 || fall_n[1] != 0) begin
      failures++;
      $display("FAIL simul_counts: r0=%0d r1=%0d f0=%0d f1=%0d, want 1 1 1 0",
               rise_n[0], rise_n[1], fall_n[0], fall_n[1]);
    end
  endtask
  task automatic test_long_press();
    int k;
    int first = -1;
    clr();
    sw = 2'b11;
    wait_db(0, 1'b1, 30, k);
    for (int j = 1; j <= 40; j++) begin
      step();
      if (long_press[0] === 1'b1 && first < 0) first = j;
    end
`ifdef DEBOUNCE_LONG_PRESS_EN
    checks++;
    if (long_n[0] != 1) begin
      failures++;
      $display("FAIL long_count: pulses=%0d, want 1", long_n[0]);
    end
    checks++;
    if (first < 17 || first > 20) begin
      failures++;
      $display("FAIL long_offset: offset=%0d, want 17..20", first);
    end
`else
    checks++;
    if (long_n[0] != 0 || long_n[1] != 0 || first != -1) begin
      failures++;
      $display("FAIL long_disabled: pulses=%0d/%0d, want 0/0", long_n[0], long_n[1]);
    end
`endif
  endtask
  initial begin
    clr();
    test_reset();
    test_bounce();
    test_hold();
    test_glitch();
    test_simultaneous();
    test_long_press();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
